// File: rtl/spi_fl_burst_rd_if.sv
// Controller port between the burst sequencer (master modport) and the SPI flash
// master's request/answer port (slave modport).
interface spi_fl_burst_rd_if;
    logic [31:0] m_data_in;
    logic [31:0] m_address;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [6:0]  m_nmiso_bits;
    logic [3:0]  m_dummy_cycles;
    logic [7:0]  m_frame_struct;
    logic        m_validflag;
    logic        m_tready;
    logic [31:0] m_data_out;

    modport master (
        output m_data_in,
        output m_address,
        output m_command,
        output m_commtype,
        output m_nmiso_bits,
        output m_dummy_cycles,
        output m_frame_struct,
        output m_validflag,
        input  m_tready,
        input  m_data_out
    );

    modport slave (
        input  m_data_in,
        input  m_address,
        input  m_command,
        input  m_commtype,
        input  m_nmiso_bits,
        input  m_dummy_cycles,
        input  m_frame_struct,
        input  m_validflag,
        output m_tready,
        output m_data_out
    );
endinterface

// File: rtl/spi_fl_burst_rd.sv
// Burst-read sequencer: splits a CPU burst into single-word flash reads and queues
// the answers in a show-ahead FIFO. Define SPI_FL_BURST_BSWAP_EN to byte-reverse each word.
module spi_fl_burst_rd #(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           cmd,
    input  logic [31:0]          base_addr,
    input  logic [7:0]           nwords,
    input  logic [3:0]           dummy_in,
    input  logic [7:0]           frame_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 rd_en,
    output logic [31:0]          rd_data,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [FIFO_AW:0]     fifo_level,
    input  logic                 flush,
    spi_fl_burst_rd_if.master    ctl
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] STORE     = 3'd4;

    localparam logic [15:0]        TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE      = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL   = (FIFO_AW + 1)'(DEPTH);

    logic [2:0]  state;
    logic [7:0]  remaining;
    logic [15:0] timeout_cnt;
    logic [31:0] rx_word;
    logic [31:0] push_data;
    logic        push;
    logic        pop;

    logic        validflag;
    logic [31:0] address;
    logic [7:0]  command;
    logic [3:0]  dummy_cycles;
    logic [7:0]  frame_struct;

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [31:0]        mem [DEPTH];

    assign ctl.m_data_in      = '0;
    assign ctl.m_nmiso_bits   = 7'd32;
    assign ctl.m_commtype     = busy ? 3'b010 : 3'b111;
    assign ctl.m_validflag    = validflag;
    assign ctl.m_address      = address;
    assign ctl.m_command      = command;
    assign ctl.m_dummy_cycles = dummy_cycles;
    assign ctl.m_frame_struct = frame_struct;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            validflag    <= 1'b0;
            address      <= '0;
            command      <= '0;
            dummy_cycles <= '0;
            frame_struct <= '0;
            remaining    <= '0;
            timeout_cnt  <= '0;
            rx_word      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        command      <= cmd;
                        address      <= base_addr;
                        dummy_cycles <= dummy_in;
                        frame_struct <= frame_in;
                        remaining    <= nwords;
                        error        <= 1'b0;
                        if (nwords == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Never request a word there is no room to store.
                    if (!fifo_full && ctl.m_tready) begin
                        validflag   <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!ctl.m_tready) begin
                        validflag <= 1'b0;
                        state     <= WAIT_DONE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        validflag <= 1'b0;
                        error     <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (ctl.m_tready) begin
                        rx_word <= ctl.m_data_out;
                        state   <= STORE;
                    end
                end
                STORE: begin
                    address   <= address + 32'd4;
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_FL_BURST_BSWAP_EN
    assign push_data = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
`else
    assign push_data = rx_word;
`endif

    assign push       = (state == STORE);
    assign pop        = rd_en && !fifo_empty;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign fifo_level = level;
    assign rd_data    = fifo_empty ? 32'd0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the reset
    // pointers and rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule
